// File: rtl/gvp_stream_pkg.sv
// Shared constants and types for the packed GVP stream (header, 48-bit time, masked channel words).
// The source side (axis_bram_stream_srcs) builds frames from the same definitions.
package gvp_stream_pkg;

  localparam int NCH_DEFAULT = 14;

  localparam logic [1:0] TYPE_FULL = 2'b10;
  localparam logic [1:0] TYPE_DATA = 2'b01;

  // Header word layout: [31:30] type, [29:16] mask (ch0 = bit 16), [15:0] index
  localparam int HDR_TYPE_LSB  = 30;
  localparam int HDR_MASK_LSB  = 16;
  localparam int HDR_INDEX_LSB = 0;
  localparam int HDR_INDEX_W   = 16;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_TLO,
    ST_THI,
    ST_CH,
    ST_DROP
  } state_t;

  function automatic logic type_ok(input logic [1:0] t);
    return (t == TYPE_FULL) || (t == TYPE_DATA);
  endfunction

endpackage

// File: rtl/axis_gvp_stream_decoder_if.sv
// AXI-Stream word channel carrying GVP frames from source to decoder.
interface axis_gvp_stream_decoder_if #(
  parameter int DW = 32
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/lsb_onehot_enc.sv
// Priority encoder: index of the lowest set bit of vec, plus a found flag.
module lsb_onehot_enc #(
  parameter int N = 14,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);
  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan downward so the lowest set bit is the last one to win.
    for (int k = N - 1; k >= 0; k--) begin
      if (vec[k]) begin
        idx   = IW'(k);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axis_gvp_stream_decoder.sv
// Unpacks GVP stream frames into a channel register bank with frame metadata;
// malformed frames are counted and the decoder resynchronises on tlast.
module axis_gvp_stream_decoder
  import gvp_stream_pkg::*;
#(
  parameter int NCH  = NCH_DEFAULT,
  parameter int DW   = 32,
  parameter int TW   = 48,
  parameter int ERRW = 16
) (
  input  logic                   a_clk,
  input  logic                   aresetn,
  axis_gvp_stream_decoder_if.slave S_AXIS,
  input  logic                   hold,
  output logic [NCH*DW-1:0]      ch_data,
  output logic [NCH-1:0]         ch_upd,
  output logic [NCH-1:0]         frame_mask,
  output logic [1:0]             frame_type,
  output logic [HDR_INDEX_W-1:0] frame_index,
  output logic [TW-1:0]          frame_time,
  output logic                   frame_valid,
  output logic                   err_pulse,
  output logic [ERRW-1:0]        err_count,
  output logic [31:0]            frame_count
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t                 state, state_n;
  logic                   xfer, tlast;
  logic [1:0]             hdr_type;
  logic [NCH-1:0]         hdr_mask;
  logic [NCH-1:0]         rem_mask, rem_next, sel, sh_mask, sh_upd, upd_next;
  logic [1:0]             sh_type;
  logic [HDR_INDEX_W-1:0] sh_index;
  logic [TW-1:0]          sh_time, time_next;
  logic [IW-1:0]          sel_idx;
  logic                   sel_found;
  logic                   done, err;

  assign S_AXIS.tready = aresetn & ~hold;
  assign xfer          = S_AXIS.tvalid & S_AXIS.tready;
  assign tlast         = S_AXIS.tlast;
  assign hdr_type      = S_AXIS.tdata[HDR_TYPE_LSB +: 2];
  assign hdr_mask      = S_AXIS.tdata[HDR_MASK_LSB +: NCH];

  lsb_onehot_enc #(.N(NCH)) u_enc (
    .vec   (rem_mask),
    .idx   (sel_idx),
    .found (sel_found)
  );

  assign sel      = sel_found ? (NCH'(1) << sel_idx) : '0;
  assign rem_next = rem_mask & ~sel;
  // Final word may land in THI (empty mask) or CH, so commit values include it.
  assign upd_next  = (state == ST_CH) ? (sh_upd | sel) : sh_upd;
  assign time_next = (state == ST_THI) ? {S_AXIS.tdata[TW-DW-1:0], sh_time[DW-1:0]} : sh_time;

  // NOTE: state and datapath registers use non-blocking assignments only.
  always_ff @(posedge a_clk or negedge aresetn) begin
    if (!aresetn) state <= ST_HDR;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    err     = 1'b0;
    if (xfer) begin
      unique case (state)
        ST_HDR: begin
          if (!type_ok(hdr_type) || tlast) begin
            err     = 1'b1;
            state_n = tlast ? ST_HDR : ST_DROP;
          end else begin
            state_n = ST_TLO;
          end
        end
        ST_TLO: begin
          err     = tlast;
          state_n = tlast ? ST_HDR : ST_THI;
        end
        ST_THI: begin
          if (sh_mask != '0) begin
            err     = tlast;
            state_n = tlast ? ST_HDR : ST_CH;
          end else begin
            done    = tlast;
            err     = !tlast;
            state_n = tlast ? ST_HDR : ST_DROP;
          end
        end
        ST_CH: begin
          if (rem_next == '0) begin
            done    = tlast;
            err     = !tlast;
            state_n = tlast ? ST_HDR : ST_DROP;
          end else if (tlast) begin
            err     = 1'b1;
            state_n = ST_HDR;
          end
        end
        ST_DROP: if (tlast) state_n = ST_HDR;
        default: state_n = ST_HDR;
      endcase
    end
  end

  // NOTE: the channel bank is plain flops, so it takes the async reset like everything else.
  always_ff @(posedge a_clk or negedge aresetn) begin
    if (!aresetn) begin
      rem_mask    <= '0;
      sh_mask     <= '0;
      sh_upd      <= '0;
      sh_type     <= '0;
      sh_index    <= '0;
      sh_time     <= '0;
      ch_data     <= '0;
      ch_upd      <= '0;
      frame_mask  <= '0;
      frame_type  <= '0;
      frame_index <= '0;
      frame_time  <= '0;
      frame_valid <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      frame_count <= '0;
    end else begin
      frame_valid <= done;
      err_pulse   <= err;
      if (xfer) begin
        case (state)
          ST_HDR: if (type_ok(hdr_type)) begin
            sh_type  <= hdr_type;
            sh_mask  <= hdr_mask;
            rem_mask <= hdr_mask;
            sh_index <= S_AXIS.tdata[HDR_INDEX_LSB +: HDR_INDEX_W];
            sh_upd   <= '0;
          end
          ST_TLO: sh_time[DW-1:0] <= S_AXIS.tdata;
          ST_THI: sh_time[TW-1:DW] <= S_AXIS.tdata[TW-DW-1:0];
          ST_CH: begin
            for (int k = 0; k < NCH; k++) begin
              if (sel[k]) ch_data[k*DW +: DW] <= S_AXIS.tdata;
            end
            sh_upd   <= upd_next;
            rem_mask <= rem_next;
          end
          default: ;
        endcase
      end
      if (done) begin
        frame_mask  <= sh_mask;
        frame_type  <= sh_type;
        frame_index <= sh_index;
        frame_time  <= time_next;
        ch_upd      <= upd_next;
        frame_count <= frame_count + 32'd1;
      end
      if (err && (err_count != '1)) err_count <= err_count + ERRW'(1);
    end
  end

endmodule

// File: tb/tb_axis_gvp_stream_decoder.sv
// Scoreboard bench for axis_gvp_stream_decoder: directed frames push expected
// results; a negedge monitor pops and compares on frame_valid / err_pulse.
module tb_axis_gvp_stream_decoder;
  import gvp_stream_pkg::*;

  localparam int NCH  = 14;
  localparam int DW   = 32;
  localparam int TW   = 48;
  localparam int ERRW = 16;

  typedef struct packed {
    logic              is_err;
    logic [1:0]        ftype;
    logic [NCH-1:0]    mask;
    logic [15:0]       index;
    logic [TW-1:0]     ftime;
    logic [NCH-1:0]    upd;
    logic [31:0]       fcount;
    logic [ERRW-1:0]   ecount;
    logic [NCH*DW-1:0] bank;
  } exp_t;

  logic a_clk, aresetn, hold, hold_en;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_upd, frame_mask;
  logic [1:0]        frame_type;
  logic [15:0]       frame_index;
  logic [TW-1:0]     frame_time;
  logic              frame_valid, err_pulse;
  logic [ERRW-1:0]   err_count;
  logic [31:0]       frame_count;

  axis_gvp_stream_decoder_if #(.DW(DW)) s_axis ();

  axis_gvp_stream_decoder #(.NCH(NCH), .DW(DW), .TW(TW), .ERRW(ERRW)) dut (
    .a_clk       (a_clk),
    .aresetn     (aresetn),
    .S_AXIS      (s_axis),
    .hold        (hold),
    .ch_data     (ch_data),
    .ch_upd      (ch_upd),
    .frame_mask  (frame_mask),
    .frame_type  (frame_type),
    .frame_index (frame_index),
    .frame_time  (frame_time),
    .frame_valid (frame_valid),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .frame_count (frame_count)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];
  exp_t m_last;
  logic [NCH*DW-1:0] m_bank;
  logic [31:0] m_fc;
  logic [ERRW-1:0] m_ec;
  logic [31:0] fw [32];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [1:0] t, input logic [13:0] m, input logic [15:0] i);
    return {t, m, i};
  endfunction

  task automatic set_ch(input int k, input logic [31:0] v);
    m_bank[k*DW +: DW] = v;
  endtask

  task automatic push_good(input logic [1:0] t, input logic [13:0] m, input logic [15:0] i,
                           input logic [47:0] tm, input logic [13:0] u);
    exp_t e;
    m_fc++;
    e.is_err = 1'b0; e.ftype = t; e.mask = m; e.index = i; e.ftime = tm; e.upd = u;
    e.fcount = m_fc; e.ecount = m_ec; e.bank = m_bank;
    m_last = e;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    m_ec++;
    e = m_last;
    e.is_err = 1'b1;
    e.ecount = m_ec;
    exp_q.push_back(e);
  endtask

  // Drives fw[0..n-1]; tl_at is the word index carrying tlast (-1 for none).
  task automatic send_words(input int n, input int tl_at);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      s_axis.tdata  = fw[i];
      s_axis.tlast  = (i == tl_at);
      s_axis.tvalid = 1'b1;
      do begin
        @(posedge a_clk);
        guard++;
      end while (!s_axis.tready && guard < 200);
      if (guard >= 200) begin
        n_tests++; n_fail++;
        $display("FAIL xfer_timeout: word %0d not accepted within %0d cycles", i, guard);
      end
      #1;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ch_data"},     ch_data, '0);
    check({tag, "_ch_upd"},      ch_upd, '0);
    check({tag, "_frame_mask"},  frame_mask, '0);
    check({tag, "_frame_type"},  frame_type, '0);
    check({tag, "_frame_index"}, frame_index, '0);
    check({tag, "_frame_time"},  frame_time, '0);
    check({tag, "_frame_valid"}, frame_valid, '0);
    check({tag, "_err_pulse"},   err_pulse, '0);
    check({tag, "_err_count"},   err_count, '0);
    check({tag, "_frame_count"}, frame_count, '0);
    check({tag, "_tready"},      s_axis.tready, '0);
  endtask

  // Monitor: tlast-transfer cycle recorded at negedge, frame_valid expected one negedge later.
  int cyc = 0;
  int tl_cyc = -10;
  always @(negedge a_clk) begin
    exp_t e;
    cyc++;
    if (aresetn) begin
      check("tready_mirror", s_axis.tready, !hold);
      if (frame_valid || err_pulse) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {frame_valid, err_pulse}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("kind_err",     err_pulse, e.is_err);
          check("kind_valid",   frame_valid, !e.is_err);
          check("frame_type",   frame_type, e.ftype);
          check("frame_mask",   frame_mask, e.mask);
          check("frame_index",  frame_index, e.index);
          check("frame_time",   frame_time, e.ftime);
          check("ch_upd",       ch_upd, e.upd);
          check("frame_count",  frame_count, e.fcount);
          check("err_count",    err_count, e.ecount);
          if (!e.is_err) begin
            check("ch_data", ch_data, e.bank);
            check("latency", cyc, tl_cyc + 1);
          end
        end
      end
      if (s_axis.tvalid && s_axis.tready && s_axis.tlast) tl_cyc = cyc;
    end
  end

  // Hold toggler changes away from both clock edges.
  initial begin
    forever begin
      @(posedge a_clk);
      #2;
      if (hold_en) hold = !hold;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0, t1;
    aresetn = 1'b0; hold = 1'b0; hold_en = 1'b0;
    s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; s_axis.tdata = '0;
    m_bank = '0; m_fc = '0; m_ec = '0; m_last = '0;
    repeat (3) @(negedge a_clk);
    check_zero("reset");
    @(posedge a_clk); #1 aresetn = 1'b1;
    repeat (2) @(posedge a_clk);
    #1;

    // Data frame, two channels; then a full 14-channel frame back-to-back
    set_ch(0, 32'd7); set_ch(1, 32'd9);
    push_good(TYPE_DATA, 14'h0003, 16'd5, 48'h0000_0000_1234, 14'h0003);
    fw[0] = hdr(2'b01, 14'h0003, 16'd5); fw[1] = 32'h1234; fw[2] = 32'h0; fw[3] = 32'd7; fw[4] = 32'd9;
    t0 = $time;
    send_words(5, 4);
    for (int k = 0; k < NCH; k++) set_ch(k, 32'(k + 1));
    push_good(TYPE_FULL, 14'h3FFF, 16'h00B0, 48'hABCD_0000_0001, 14'h3FFF);
    fw[0] = hdr(2'b10, 14'h3FFF, 16'h00B0); fw[1] = 32'h0000_0001; fw[2] = 32'h0000_ABCD;
    for (int k = 0; k < NCH; k++) fw[3 + k] = 32'(k + 1);
    send_words(17, 16);
    t1 = $time;
    check("no_bubbles_ns", 64'(t1 - t0), 64'd220);

    // Empty mask, tlast on W2: good frame with no channel updates
    push_good(TYPE_DATA, 14'h0, 16'd7, 48'h0055_0000_0066, 14'h0);
    fw[0] = hdr(2'b01, 14'h0, 16'd7); fw[1] = 32'h66; fw[2] = 32'h55;
    send_words(3, 2);

    // Empty mask, no tlast on W2: error, then drop until tlast
    push_err();
    fw[0] = hdr(2'b01, 14'h0, 16'd8); fw[1] = 32'h1; fw[2] = 32'h0; fw[3] = 32'hDEAD; fw[4] = 32'hBEEF;
    send_words(5, 4);

    // Three-channel frame, then early tlast on the 2nd channel word, then recovery
    set_ch(4, 32'h40); set_ch(5, 32'h50); set_ch(6, 32'h60);
    push_good(TYPE_FULL, 14'h0070, 16'd9, 48'h10, 14'h0070);
    fw[0] = hdr(2'b10, 14'h0070, 16'd9); fw[1] = 32'h10; fw[2] = 32'h0;
    fw[3] = 32'h40; fw[4] = 32'h50; fw[5] = 32'h60;
    send_words(6, 5);
    push_err();
    fw[0] = hdr(2'b10, 14'h0070, 16'd10); fw[1] = 32'h20; fw[2] = 32'h0; fw[3] = 32'h41; fw[4] = 32'h51;
    send_words(5, 4);
    set_ch(4, 32'h42); set_ch(5, 32'h52); set_ch(6, 32'h62);
    push_good(TYPE_FULL, 14'h0070, 16'd11, 48'h30, 14'h0070);
    fw[0] = hdr(2'b10, 14'h0070, 16'd11); fw[1] = 32'h30; fw[2] = 32'h0;
    fw[3] = 32'h42; fw[4] = 32'h52; fw[5] = 32'h62;
    send_words(6, 5);

    // Bad header types: 11 drops to tlast, 00 with tlast on the header itself
    push_err();
    fw[0] = hdr(2'b11, 14'h0001, 16'd1); fw[1] = 32'hCAFE; fw[2] = 32'hF00D;
    send_words(3, 2);
    push_err();
    fw[0] = hdr(2'b00, 14'h0001, 16'd2);
    send_words(1, 0);

    // Backpressure toggling every other cycle during a 4-channel frame
    hold_en = 1'b1;
    set_ch(4, 32'hA4); set_ch(5, 32'hA5); set_ch(6, 32'hA6); set_ch(7, 32'hA7);
    push_good(TYPE_DATA, 14'h00F0, 16'h0020, 48'h777, 14'h00F0);
    fw[0] = hdr(2'b01, 14'h00F0, 16'h0020); fw[1] = 32'h777; fw[2] = 32'h0;
    fw[3] = 32'hA4; fw[4] = 32'hA5; fw[5] = 32'hA6; fw[6] = 32'hA7;
    send_words(7, 6);
    hold_en = 1'b0;
    hold = 1'b0;
    repeat (3) @(posedge a_clk);
    #1;

    // Reset in the middle of the channel words
    fw[0] = hdr(2'b01, 14'h0300, 16'h0030); fw[1] = 32'h1; fw[2] = 32'h0; fw[3] = 32'h88;
    send_words(4, -1);
    aresetn = 1'b0;
    @(negedge a_clk);
    check_zero("midreset");
    m_bank = '0; m_fc = '0; m_ec = '0; m_last = '0;
    @(posedge a_clk); #1 aresetn = 1'b1;
    @(negedge a_clk);
    check("post_reset_err_pulse", err_pulse, 1'b0);
    @(posedge a_clk); #1;

    set_ch(0, 32'h11);
    push_good(TYPE_DATA, 14'h0001, 16'd1, 48'h2, 14'h0001);
    fw[0] = hdr(2'b01, 14'h0001, 16'd1); fw[1] = 32'h2; fw[2] = 32'h0; fw[3] = 32'h11;
    send_words(4, 3);

    repeat (5) @(negedge a_clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
